// File: rtl/uart_rx_frame.sv
// UART receive frame engine: oversampled start detection, 2-of-3 majority bit sampling,
// LSB-first deserialization, optional parity check and stop-bit check with one-cycle result pulses.
module uart_rx_frame #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err
);

    localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    logic [PRESCALE_W-1:0]   p_reg;
    logic                    pe_reg;
    logic                    pt_reg;
    logic [PRESCALE_W-1:0]   edge_cnt;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    s_lo;
    logic                    s_mid;
    logic                    sample;
    logic                    par_flag;

    // Sample-point decode relative to the captured prescale
    logic [PRESCALE_W-1:0] half;
    logic                  bit_end;
    logic                  at_lo;
    logic                  at_mid;
    logic                  at_hi;
    logic                  maj;

    assign half    = p_reg >> 1;
    assign bit_end = (edge_cnt == PRESCALE_W'(p_reg - PRESCALE_W'(1)));
    assign at_lo   = (edge_cnt == PRESCALE_W'(half - PRESCALE_W'(1)));
    assign at_mid  = (edge_cnt == half);
    assign at_hi   = (edge_cnt == PRESCALE_W'(half + PRESCALE_W'(1)));
    assign maj     = (s_lo & s_mid) | (s_lo & rx_in) | (s_mid & rx_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            p_reg      <= '0;
            pe_reg     <= 1'b0;
            pt_reg     <= 1'b0;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            s_lo       <= 1'b0;
            s_mid      <= 1'b0;
            sample     <= 1'b0;
            par_flag   <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;

            // Bit timing and majority sampling run in every non-idle state
            if (state != IDLE) begin
                edge_cnt <= bit_end ? '0 : PRESCALE_W'(edge_cnt + PRESCALE_W'(1));
                if (at_lo)  s_lo   <= rx_in;
                if (at_mid) s_mid  <= rx_in;
                if (at_hi)  sample <= maj;
            end

            case (state)
                IDLE: begin
                    if (!rx_in) begin
                        // The detecting cycle is edge 0 of the start bit
                        state    <= START;
                        edge_cnt <= PRESCALE_W'(1);
                        p_reg    <= prescale;
                        pe_reg   <= par_en;
                        pt_reg   <= par_typ;
                        bit_cnt  <= '0;
                        par_flag <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) state <= sample ? IDLE : DATA;
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= {sample, shift_reg[DATA_WIDTH-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= pe_reg ? PARITY : STOP;
                        end else begin
                            bit_cnt <= BIT_CNT_W'(bit_cnt + BIT_CNT_W'(1));
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        par_flag <= (sample != ((^shift_reg) ^ pt_reg));
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        p_data     <= shift_reg;
                        data_valid <= !par_flag && sample;
                        par_err    <= par_flag;
                        stop_err   <= !sample;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: a frame-level model queues expected results, a monitor
// checks every output pulse against them, including arrival cycle.
module tb_uart_rx_frame;

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_in = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stop_err;

    uart_rx_frame #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stop_err   (stop_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          valid;
        logic          perr;
        logic          serr;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int nchecks = 0;
    int nerrors = 0;

    task automatic check(input string name, input int act, input int exp_v);
        nchecks++;
        if (act != exp_v) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding frame
    always @(negedge clk) begin
        exp_t e;
        if (rst && (data_valid || par_err || stop_err)) begin
            if (q.size() == 0) begin
                nchecks++;
                nerrors++;
                $display("FAIL unexpected_pulse: dv=%0b pe=%0b se=%0b p_data=%02h with none expected at cycle %0d",
                         data_valid, par_err, stop_err, p_data, cyc);
            end else begin
                e = q.pop_front();
                check("p_data", int'(p_data), int'(e.data));
                check("data_valid", int'(data_valid), int'(e.valid));
                check("par_err", int'(par_err), int'(e.perr));
                check("stop_err", int'(stop_err), int'(e.serr));
                check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic int rand_prescale();
        int sel = int'($urandom_range(0, 2));
        return (sel == 0) ? 8 : ((sel == 1) ? 16 : 32);
    endfunction

    // Drives one frame starting at a negedge and queues the model's expected result
    task automatic send_frame(input int p, input bit pe, input bit pt, input logic [DW-1:0] d,
                              input bit bad_par, input bit bad_stop, input bit scramble);
        exp_t e;
        int   nbits;
        logic pbit;
        nbits = 1 + DW + (pe ? 1 : 0) + 1;
        pbit = (^d) ^ pt ^ bad_par;
        prescale = PW'(p);
        par_en = pe;
        par_typ = pt;
        e.data = d;
        e.perr = pe && bad_par;
        e.serr = bad_stop;
        e.valid = !(pe && bad_par) && !bad_stop;
        e.cyc = cyc + nbits * p;
        q.push_back(e);
        rx_in = 1'b0;
        @(negedge clk);
        if (scramble) begin
            prescale = PW'(rand_prescale());
            par_en = 1'($urandom);
            par_typ = 1'($urandom);
        end
        repeat (p - 1) @(negedge clk);
        for (int i = 0; i < int'(DW); i++) begin
            rx_in = d[i];
            repeat (p) @(negedge clk);
        end
        if (pe) begin
            rx_in = pbit;
            repeat (p) @(negedge clk);
        end
        rx_in = !bad_stop;
        repeat (p) @(negedge clk);
        rx_in = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic glitch(input int p, input int g);
        prescale = PW'(p);
        rx_in = 1'b0;
        repeat (g) @(negedge clk);
        rx_in = 1'b1;
        repeat (p + 2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_p_data", int'(p_data), 0);
        check("reset_data_valid", int'(data_valid), 0);
        check("reset_par_err", int'(par_err), 0);
        check("reset_stop_err", int'(stop_err), 0);
        rst = 1'b1;
        idle(4);

        send_frame(8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        idle(3);
        send_frame(16, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        idle(3);
        send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0);
        idle(20);
        glitch(8, 2);
        send_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Abort frame 0x77 in its data bits with reset; nothing from it may surface
        prescale = PW'(16);
        par_en = 1'b0;
        rx_in = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_in = (8'h77 >> i) & 8'h01;
            repeat (16) @(negedge clk);
        end
        rst = 1'b0;
        #1;
        check("midreset_p_data", int'(p_data), 0);
        check("midreset_data_valid", int'(data_valid), 0);
        check("midreset_par_err", int'(par_err), 0);
        check("midreset_stop_err", int'(stop_err), 0);
        @(negedge clk);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(2);
        send_frame(16, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);
        idle(2);

        for (int n = 0; n < 40; n++) begin
            int p;
            bit pe;
            p = rand_prescale();
            pe = 1'($urandom);
            if ($urandom_range(0, 5) == 0) glitch(p, int'($urandom_range(1, p / 2 - 2)));
            send_frame(p, pe, 1'($urandom), DW'($urandom), pe && ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 4) == 0), 1'b1);
            idle(int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", q.size(), 0);
        idle(100);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
